// File: rtl/bc_shared_reg_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bc_shared_reg_arb_pkg
//  Brief    : Shared types and width helpers for the shared-register arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package bc_shared_reg_arb_pkg;

    // Arbiter mode: free round-robin, or a requester holding a burst lock.
    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arbState_t;

    // Bits needed to index n requesters (at least one bit).
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to count 0..m inclusive.
    function automatic int cntWidth(input int m);
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bc_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : bc_rr_pick
//  Brief    : Combinational round-robin search: first set request bit at or
//             after a start index, wrapping from NUM_REQ-1 back to 0.
//  Revision : 1.0  initial release
// ============================================================================
module bc_rr_pick
    import bc_shared_reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = idxWidth(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] iReq,
    input  logic [IDXW-1:0]    iStart,
    output logic [NUM_REQ-1:0] oOneHot,
    output logic [IDXW-1:0]    oIdx,
    output logic               oFound
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDXW-1:0]      w_ofs;
    logic [IDXW:0]        w_sum;

    // Rotate the request vector so iStart lands on bit 0, then take the lowest set offset.
    always_comb begin
        w_dbl = {iReq, iReq} >> iStart;
        w_rot = w_dbl[NUM_REQ-1:0];
        w_ofs = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_ofs = IDXW'(k);
            end
        end
    end

    // Map the offset back to an absolute index, wrapping past the last requester.
    always_comb begin
        w_sum = {1'b0, iStart} + {1'b0, w_ofs};
        if (w_sum >= (IDXW+1)'(NUM_REQ)) begin
            w_sum = w_sum - (IDXW+1)'(NUM_REQ);
        end
        oFound  = |iReq;
        oIdx    = w_sum[IDXW-1:0];
        oOneHot = oFound ? (NUM_REQ'(1) << oIdx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/bc_shared_reg_arb.sv
`default_nettype none
// ============================================================================
//  Module   : bc_shared_reg_arb
//  Brief    : Shared register written by NUM_REQ requesters under round-robin
//             arbitration, with capped burst locking (MAX_HOLD writes).
//  Revision : 1.0  initial release
// ============================================================================
module bc_shared_reg_arb
    import bc_shared_reg_arb_pkg::*;
#(
    parameter int               NUM_REQ  = 4,
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = '0,
    parameter int               MAX_HOLD = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            iReq,
    input  logic [NUM_REQ-1:0]            iLock,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] iDat,
    output logic [NUM_REQ-1:0]            oGnt,
    output logic [WIDTH-1:0]              oDat,
    output logic [$clog2(NUM_REQ)-1:0]    oOwner,
    output logic                          oValid
);

    localparam int                c_IDXW     = idxWidth(NUM_REQ);
    localparam int                c_CNTW     = cntWidth(MAX_HOLD);
    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(NUM_REQ - 1);
    localparam logic [c_CNTW:0]   c_MAX_HOLD = (c_CNTW+1)'(MAX_HOLD);
    localparam bit                c_LOCK_EN  = (MAX_HOLD > 1);

    arbState_t           r_state;
    arbState_t           w_stateNxt;
    logic [c_IDXW-1:0]   r_ptr;
    logic [c_IDXW-1:0]   w_ptrNxt;
    logic [c_CNTW-1:0]   r_cnt;
    logic [c_CNTW-1:0]   w_cntNxt;
    logic [c_CNTW:0]     w_cntInc;
    logic [WIDTH-1:0]    r_dat;
    logic [c_IDXW-1:0]   r_owner;
    logic                r_valid;

    logic                w_hold;
    logic [c_IDXW-1:0]   w_start;
    logic [c_IDXW-1:0]   w_ownerInc;
    logic [c_IDXW-1:0]   w_pickInc;
    logic [NUM_REQ-1:0]  w_pickOneHot;
    logic [c_IDXW-1:0]   w_pickIdx;
    logic                w_pickFound;
    logic [NUM_REQ-1:0]  w_gnt;
    logic                w_wr;
    logic [c_IDXW-1:0]   w_wIdx;

    // While LOCKED the last writer is the lock owner, so r_owner doubles as the lock holder.
    assign w_hold     = (r_state == LOCKED) && iReq[r_owner] && iLock[r_owner];
    assign w_ownerInc = (r_owner == c_LAST_IDX) ? '0 : r_owner + c_IDXW'(1);
    assign w_pickInc  = (w_pickIdx == c_LAST_IDX) ? '0 : w_pickIdx + c_IDXW'(1);
    // A released lock searches from just past the owner so the owner is considered last.
    assign w_start    = (r_state == LOCKED) ? w_ownerInc : r_ptr;
    assign w_cntInc   = {1'b0, r_cnt} + (c_CNTW+1)'(1);

    bc_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (c_IDXW)
    ) u_pick (
        .iReq    (iReq),
        .iStart  (w_start),
        .oOneHot (w_pickOneHot),
        .oIdx    (w_pickIdx),
        .oFound  (w_pickFound)
    );

    // Next-state, pointer/counter update and same-cycle grant decode.
    always_comb begin
        w_stateNxt = r_state;
        w_ptrNxt   = r_ptr;
        w_cntNxt   = r_cnt;
        w_gnt      = '0;
        w_wr       = 1'b0;
        w_wIdx     = w_pickIdx;
        if (w_hold) begin
            w_gnt  = NUM_REQ'(1) << r_owner;
            w_wr   = 1'b1;
            w_wIdx = r_owner;
            if (w_cntInc == c_MAX_HOLD) begin
                w_stateNxt = ARB;
                w_ptrNxt   = w_ownerInc;
                w_cntNxt   = '0;
            end else begin
                w_cntNxt   = w_cntInc[c_CNTW-1:0];
            end
        end else if (w_pickFound) begin
            w_gnt = w_pickOneHot;
            w_wr  = 1'b1;
            if (c_LOCK_EN && iLock[w_pickIdx]) begin
                // Pointer stays put during a tenure; it advances when the tenure ends.
                w_stateNxt = LOCKED;
                w_cntNxt   = c_CNTW'(1);
            end else begin
                w_stateNxt = ARB;
                w_ptrNxt   = w_pickInc;
                w_cntNxt   = '0;
            end
        end else if (r_state == LOCKED) begin
            // Owner let go and nobody else wants the register: end the tenure.
            w_stateNxt = ARB;
            w_ptrNxt   = w_ownerInc;
            w_cntNxt   = '0;
        end
        if (!rst) begin
            w_gnt = '0;
            w_wr  = 1'b0;
        end
    end

    // Arbiter state, pointer and tenure counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ARB;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNxt;
            r_ptr   <= w_ptrNxt;
            r_cnt   <= w_cntNxt;
        end
    end

    // Shared register: captures the granted requester's data on a completed write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dat   <= INI_DATA;
            r_owner <= '0;
            r_valid <= 1'b0;
        end else if (w_wr) begin
            r_dat   <= iDat[w_wIdx];
            r_owner <= w_wIdx;
            r_valid <= 1'b1;
        end
    end

    assign oGnt   = w_gnt;
    assign oDat   = r_dat;
    assign oOwner = r_owner;
    assign oValid = r_valid;

endmodule
`default_nettype wire

// File: doc/bc_shared_reg_arb.md
BC_SHARED_REG_ARB -- requirements
Module: bc_shared_reg_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter WIDTH, default 32, data width.
REQ-003 SHALL have parameter INI_DATA, default WIDTH'h0, shared register reset value.
REQ-004 SHALL have parameter MAX_HOLD, default 4, maximum consecutive writes per lock tenure (>=1).
REQ-005 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port iReq  input  NUM_REQ  per-requester write request.
REQ-008 SHALL have port iLock  input  NUM_REQ  per-requester lock (burst) request; qualified by iReq.
REQ-009 SHALL have port iDat  input  NUM_REQ x WIDTH  per-requester write data.
REQ-010 SHALL have port oGnt  output  NUM_REQ  one-hot or zero grant, combinational, same cycle as request.
REQ-011 SHALL have port oDat  output  WIDTH  shared register value.
REQ-012 SHALL have port oOwner  output  $clog2(NUM_REQ)  index of last writer, registered.
REQ-013 SHALL have port oValid  output  1  high once any write has completed since reset.

Function
REQ-014 SHALL complete a write when oGnt[i]&iReq[i] at a rising edge: oDat <= iDat[i], oOwner <= i, oValid <= 1; oDat latency 1 cycle from grant.
REQ-015 SHALL assert at most one oGnt bit per cycle; oGnt SHALL be zero when iReq is zero or rst is low.
REQ-016 SHALL hold oDat, oOwner, oValid unchanged in any cycle without a grant.
REQ-017 SHALL implement states ARB and LOCKED plus registered rotate pointer ptr and hold counter cnt.
REQ-018 In ARB: grant the first requester at or after ptr (wrapping NUM_REQ-1 -> 0).
REQ-019 In ARB, on grant to w with iLock[w]=1 and MAX_HOLD>1: next state LOCKED, owner=w, cnt=1, ptr unchanged; otherwise ptr <= (w+1) mod NUM_REQ.
REQ-020 In LOCKED with iReq[owner]&iLock[owner]: grant only owner, cnt <= cnt+1; if cnt+1==MAX_HOLD, next state ARB, ptr <= (owner+1) mod NUM_REQ.
REQ-021 In LOCKED with iReq[owner]=0 or iLock[owner]=0: same cycle behaves as ARB with search starting at (owner+1) mod NUM_REQ (owner eligible last), no bubble; next state per REQ-019.
REQ-022 Other requesters SHALL receive no grant while LOCKED per REQ-020.
REQ-023 Starvation bound: any continuously requesting requester SHALL be granted within (NUM_REQ-1)*MAX_HOLD+1 cycles.
REQ-024 cnt SHALL be $clog2(MAX_HOLD+1) bits and never exceed MAX_HOLD.

Reset
REQ-025 While rst=0 at a rising edge: oDat=INI_DATA, oOwner=0, oValid=0, state=ARB, ptr=0, cnt=0; no write occurs.
REQ-026 Reset mid-lock SHALL abandon the tenure; first post-reset arbitration starts at index 0.

Structure
REQ-027 Package bc_shared_reg_arb_pkg SHALL hold the state enum (ARB, LOCKED) and index/counter width helper functions.
REQ-028 Sub-module bc_rr_pick SHALL implement combinational round-robin search (req vector, start index -> one-hot, index, found); instantiated once.

Verification (NUM_REQ=4, WIDTH=32, INI_DATA=32'h1, MAX_HOLD=4)
REQ-029 Reset: rst=0 two cycles, random iReq -> oGnt=0, oDat=32'h1, oValid=0, oOwner=0.
REQ-030 Rotation: iReq=4'b1111, iLock=0, iDat[i]=i+10 -> grants 0,1,2,3,0; oDat 10,11,12,13 one cycle after each.
REQ-031 Lock cap: iReq=4'b0011, iLock[0]=1 -> req0 granted 4 cycles, then req1 granted; oDat=iDat[0] through cycle 4.
REQ-032 Early release: req0 locked, drops iLock after 2 writes, iReq=4'b0101 -> req2 granted that same cycle, no bubble.
REQ-033 Reset mid-lock: rst=0 during 3rd locked write -> no write, oDat=32'h1; after release iReq=4'b1010 -> req1 granted first.
REQ-034 Idle: iReq=0 for 5 cycles after writes -> oGnt=0, oDat/oOwner stable, ptr unchanged.
